// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// Decode-to-execute pipeline register of the 5-stage RV32I core.
// Captures the decode-stage control fields, operands and register indices on
// every rising edge. flush_E (priority) loads a bubble, and stall_E holds the
// stage. The block also flags a load-use hazard by comparing the registered
// E-stage destination against the incoming D-stage sources.
//
// Handshake note: there is no valid/ready pair here. valid_E marks that the
// E stage holds a real instruction rather than a bubble or reset value.
// Upstream control owns flow: stall_E freezes the stage and flush_E squashes it.
// lw_stall is only reported. It is never fed back into the stage internally;
// the hazard unit turns it into flush_E and the F/D stall.

module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_E,
    input  logic              flush_E,
    // decode-stage control
    input  logic [1:0]        jump_D,
    input  logic              branch_D,
    input  logic [2:0]        bropcode_D,
    input  logic [1:0]        store_sel_D,
    input  logic [2:0]        load_sel_D,
    input  logic [9:0]        alu_ctrl_D,
    input  logic              alu_srcA_D,
    input  logic              alu_srcB_D,
    input  logic              regWrite_D,
    input  logic              memWrite_D,
    input  logic [1:0]        write_back_D,
    // decode-stage operands
    input  logic [XLEN-1:0]   rd1_D,
    input  logic [XLEN-1:0]   rd2_D,
    input  logic [XLEN-1:0]   pc_D,
    input  logic [XLEN-1:0]   pc_plus4_D,
    input  logic [XLEN-1:0]   imm_ext_D,
    // decode-stage register indices
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rd_D,
    // execute-stage control
    output logic [1:0]        jump_E,
    output logic              branch_E,
    output logic [2:0]        bropcode_E,
    output logic [1:0]        store_sel_E,
    output logic [2:0]        load_sel_E,
    output logic [9:0]        alu_ctrl_E,
    output logic              alu_srcA_E,
    output logic              alu_srcB_E,
    output logic              regWrite_E,
    output logic              memWrite_E,
    output logic [1:0]        write_back_E,
    // execute-stage operands
    output logic [XLEN-1:0]   rd1_E,
    output logic [XLEN-1:0]   rd2_E,
    output logic [XLEN-1:0]   pc_E,
    output logic [XLEN-1:0]   pc_plus4_E,
    output logic [XLEN-1:0]   imm_ext_E,
    // execute-stage register indices
    output logic [REG_AW-1:0] rs1_E,
    output logic [REG_AW-1:0] rs2_E,
    output logic [REG_AW-1:0] rd_E,
    // status
    output logic              valid_E,
    output logic              lw_stall
);

    // Bubble encoding: a harmless add that writes nothing and touches no memory.
    localparam logic [1:0] BUB_JUMP       = 2'b00;
    localparam logic       BUB_BRANCH     = 1'b0;
    localparam logic [2:0] BUB_BROPCODE   = 3'b010;
    localparam logic [1:0] BUB_STORE_SEL  = 2'b11;
    localparam logic [2:0] BUB_LOAD_SEL   = 3'b111;
    localparam logic [9:0] BUB_ALU_CTRL   = 10'd1;
    localparam logic       BUB_ALU_SRCA   = 1'b0;
    localparam logic       BUB_ALU_SRCB   = 1'b0;
    localparam logic       BUB_REGWRITE   = 1'b0;
    localparam logic       BUB_MEMWRITE   = 1'b0;
    localparam logic [1:0] BUB_WRITE_BACK = 2'b00;

    // Write-back select value that marks a load result.
    localparam logic [1:0] WB_MEM = 2'b01;

    // control registers
    logic [1:0]        r_jump_E;
    logic              r_branch_E;
    logic [2:0]        r_bropcode_E;
    logic [1:0]        r_store_sel_E;
    logic [2:0]        r_load_sel_E;
    logic [9:0]        r_alu_ctrl_E;
    logic              r_alu_srcA_E;
    logic              r_alu_srcB_E;
    logic              r_regWrite_E;
    logic              r_memWrite_E;
    logic [1:0]        r_write_back_E;
    // operand registers
    logic [XLEN-1:0]   r_rd1_E;
    logic [XLEN-1:0]   r_rd2_E;
    logic [XLEN-1:0]   r_pc_E;
    logic [XLEN-1:0]   r_pc_plus4_E;
    logic [XLEN-1:0]   r_imm_ext_E;
    // index registers
    logic [REG_AW-1:0] r_rs1_E;
    logic [REG_AW-1:0] r_rs2_E;
    logic [REG_AW-1:0] r_rd_E;
    // occupancy
    logic              r_valid_E;

    // update qualifiers: flush wins over stall, a plain load happens otherwise
    logic w_bubble;
    logic w_load;

    // hazard detection terms
    logic w_e_is_load;
    logic w_rd_nonzero;
    logic w_rs1_match;
    logic w_rs2_match;

    // Decode the per-edge action once so every register group agrees on it.
    always_comb begin
        w_bubble = flush_E;
        w_load   = ~flush_E & ~stall_E;
    end

    // Control fields: bubble on reset or flush, copy on load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_E       <= BUB_JUMP;
            r_branch_E     <= BUB_BRANCH;
            r_bropcode_E   <= BUB_BROPCODE;
            r_store_sel_E  <= BUB_STORE_SEL;
            r_load_sel_E   <= BUB_LOAD_SEL;
            r_alu_ctrl_E   <= BUB_ALU_CTRL;
            r_alu_srcA_E   <= BUB_ALU_SRCA;
            r_alu_srcB_E   <= BUB_ALU_SRCB;
            r_regWrite_E   <= BUB_REGWRITE;
            r_memWrite_E   <= BUB_MEMWRITE;
            r_write_back_E <= BUB_WRITE_BACK;
        end else if (w_bubble) begin
            r_jump_E       <= BUB_JUMP;
            r_branch_E     <= BUB_BRANCH;
            r_bropcode_E   <= BUB_BROPCODE;
            r_store_sel_E  <= BUB_STORE_SEL;
            r_load_sel_E   <= BUB_LOAD_SEL;
            r_alu_ctrl_E   <= BUB_ALU_CTRL;
            r_alu_srcA_E   <= BUB_ALU_SRCA;
            r_alu_srcB_E   <= BUB_ALU_SRCB;
            r_regWrite_E   <= BUB_REGWRITE;
            r_memWrite_E   <= BUB_MEMWRITE;
            r_write_back_E <= BUB_WRITE_BACK;
        end else if (w_load) begin
            r_jump_E       <= jump_D;
            r_branch_E     <= branch_D;
            r_bropcode_E   <= bropcode_D;
            r_store_sel_E  <= store_sel_D;
            r_load_sel_E   <= load_sel_D;
            r_alu_ctrl_E   <= alu_ctrl_D;
            r_alu_srcA_E   <= alu_srcA_D;
            r_alu_srcB_E   <= alu_srcB_D;
            r_regWrite_E   <= regWrite_D;
            r_memWrite_E   <= memWrite_D;
            r_write_back_E <= write_back_D;
        end
    end

    // Operand fields: zero on reset or flush, copy on load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1_E      <= '0;
            r_rd2_E      <= '0;
            r_pc_E       <= '0;
            r_pc_plus4_E <= '0;
            r_imm_ext_E  <= '0;
        end else if (w_bubble) begin
            r_rd1_E      <= '0;
            r_rd2_E      <= '0;
            r_pc_E       <= '0;
            r_pc_plus4_E <= '0;
            r_imm_ext_E  <= '0;
        end else if (w_load) begin
            r_rd1_E      <= rd1_D;
            r_rd2_E      <= rd2_D;
            r_pc_E       <= pc_D;
            r_pc_plus4_E <= pc_plus4_D;
            r_imm_ext_E  <= imm_ext_D;
        end
    end

    // Register indices: zero on reset or flush, copy on load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_E <= '0;
            r_rs2_E <= '0;
            r_rd_E  <= '0;
        end else if (w_bubble) begin
            r_rs1_E <= '0;
            r_rs2_E <= '0;
            r_rd_E  <= '0;
        end else if (w_load) begin
            r_rs1_E <= rs1_D;
            r_rs2_E <= rs2_D;
            r_rd_E  <= rd_D;
        end
    end

    // Occupancy flag: set by a load, cleared by reset or flush, held on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_E <= 1'b0;
        end else if (w_bubble) begin
            r_valid_E <= 1'b0;
        end else if (w_load) begin
            r_valid_E <= 1'b1;
        end
    end

    // Load-use hazard: a real load in E writing a non-x0 register that the
    // instruction now in D reads. The bubble has regWrite=0 and valid=0, so
    // reset and flushed cycles never raise it.
    always_comb begin
        w_e_is_load  = r_valid_E & r_regWrite_E & (r_write_back_E == WB_MEM);
        w_rd_nonzero = |r_rd_E;
        w_rs1_match  = (r_rd_E == rs1_D);
        w_rs2_match  = (r_rd_E == rs2_D);
        lw_stall     = w_e_is_load & w_rd_nonzero & (w_rs1_match | w_rs2_match);
    end

    // Drive the stage outputs straight from the registers.
    always_comb begin
        jump_E       = r_jump_E;
        branch_E     = r_branch_E;
        bropcode_E   = r_bropcode_E;
        store_sel_E  = r_store_sel_E;
        load_sel_E   = r_load_sel_E;
        alu_ctrl_E   = r_alu_ctrl_E;
        alu_srcA_E   = r_alu_srcA_E;
        alu_srcB_E   = r_alu_srcB_E;
        regWrite_E   = r_regWrite_E;
        memWrite_E   = r_memWrite_E;
        write_back_E = r_write_back_E;
        rd1_E        = r_rd1_E;
        rd2_E        = r_rd2_E;
        pc_E         = r_pc_E;
        pc_plus4_E   = r_pc_plus4_E;
        imm_ext_E    = r_imm_ext_E;
        rs1_E        = r_rs1_E;
        rs2_E        = r_rs2_E;
        rd_E         = r_rd_E;
        valid_E      = r_valid_E;
    end

endmodule
